// File: rtl/alu_sequencer_if.sv
// Bus bundle between the instruction source, the ALU sequencer and the register/ALU datapath.
// master = sequencer side (consumes EXEC/INSTR, drives controls); slave = the other side.
interface alu_sequencer_if #(
    parameter int N    = 10,
    parameter int NREG = 8
);
    // Request handshake: EXEC acts as a valid that is only accepted while the
    // sequencer is idle (T0); BUSY low is the matching ready, and IRin marks the
    // acceptance cycle. EXEC seen while busy is dropped, never queued.
    logic            EXEC;
    logic [N-1:0]    INSTR;
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            EXTERN;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic [3:0]      FN;
    logic            BUSY;
    logic            DONE;
    logic            ILLEGAL;

    modport master (
        input  EXEC, INSTR,
        output IRin, Rin, Rout, EXTERN, Ain, Gin, Gout, FN, BUSY, DONE, ILLEGAL
    );

    modport slave (
        output EXEC, INSTR,
        input  IRin, Rin, Rout, EXTERN, Ain, Gin, Gout, FN, BUSY, DONE, ILLEGAL
    );
endinterface

// File: rtl/alu_sequencer.sv
// T0..T3 control sequencer for the multi-stage ALU: captures {FN, Rx, Ry} on EXEC and
// steps the bus/ALU controls. Optional macro ILLEGAL_TRAP_EN flags reserved opcodes on ILLEGAL.
module alu_sequencer #(
    parameter int N    = 10,
    parameter int NREG = 8
) (
    input  logic          CLKb,
    input  logic          RSTb,
    alu_sequencer_if.master bus,
    output logic [1:0]    dbg_state
);
    localparam int R = $clog2(NREG);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_FLP  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;

    typedef struct packed {
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout;
        logic            ext;
        logic            ain;
        logic            gin;
        logic            gout;
        logic [3:0]      fn;
        logic            done;
        logic            ill;
    } ctrl_t;

    state_t          state;
    logic [3:0]      ir_op;
    logic [R-1:0]    ir_rx;
    logic [R-1:0]    ir_ry;
    ctrl_t           ctrl;

    // Register indices that do not exist (non power-of-2 NREG) select nothing.
    function automatic logic [NREG-1:0] onehot(input logic [R-1:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREG; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    function automatic state_t advance(input state_t st);
        state_t nx;
        case (st)
            T1:      nx = T2;
            T2:      nx = T3;
            default: nx = T0;
        endcase
        return nx;
    endfunction

    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_INV) || (op == OP_FLP) || (op == OP_LSL) ||
               (op == OP_LSR) || (op == OP_ASR);
    endfunction

    // Control word to present while in step st for the given instruction.
    function automatic ctrl_t decode(input state_t st, input logic [3:0] op,
                                     input logic [R-1:0] rx, input logic [R-1:0] ry);
        ctrl_t c;
        c = '0;
        if (op == OP_LOAD) begin
            if (st == T1) begin
                c.ext  = 1'b1;
                c.rin  = onehot(rx);
                c.done = 1'b1;
            end
        end else if (op == OP_MOV) begin
            if (st == T1) begin
                c.rout = onehot(ry);
                c.rin  = onehot(rx);
                c.done = 1'b1;
            end
        end else if (is_binary(op)) begin
            case (st)
                T1: begin
                    c.rout = onehot(rx);
                    c.ain  = 1'b1;
                end
                T2: begin
                    c.rout = onehot(ry);
                    c.gin  = 1'b1;
                    c.fn   = op;
                end
                T3: begin
                    c.gout = 1'b1;
                    c.rin  = onehot(rx);
                    c.done = 1'b1;
                end
                default: c = '0;
            endcase
        end else if (is_unary(op)) begin
            case (st)
                T1: begin
                    c.rout = onehot(ry);
                    c.gin  = 1'b1;
                    c.fn   = op;
                end
                T2: begin
                    c.gout = 1'b1;
                    c.rin  = onehot(rx);
                    c.done = 1'b1;
                end
                default: c = '0;
            endcase
        end else begin
            // Reserved opcodes finish in one step without touching the datapath.
            if (st == T1) begin
                c.done = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                c.ill  = 1'b1;
`else
                c.ill  = 1'b0;
`endif
            end
        end
        return c;
    endfunction

    always_ff @(posedge CLKb) begin
        if (!RSTb) begin
            state <= T0;
            ir_op <= '0;
            ir_rx <= '0;
            ir_ry <= '0;
            ctrl  <= '0;
        end else if (state == T0) begin
            if (bus.EXEC) begin
                ir_op <= bus.INSTR[N-1 -: 4];
                ir_rx <= bus.INSTR[N-5 -: R];
                ir_ry <= bus.INSTR[N-5-R -: R];
                state <= T1;
                ctrl  <= decode(T1, bus.INSTR[N-1 -: 4], bus.INSTR[N-5 -: R],
                                bus.INSTR[N-5-R -: R]);
            end else begin
                ctrl <= '0;
            end
        end else if (ctrl.done) begin
            state <= T0;
            ctrl  <= '0;
        end else begin
            state <= advance(state);
            ctrl  <= decode(advance(state), ir_op, ir_rx, ir_ry);
        end
    end

    // IRin is the only output allowed to follow EXEC combinationally.
    assign bus.IRin    = bus.EXEC & (state == T0);
    assign bus.Rin     = ctrl.rin;
    assign bus.Rout    = ctrl.rout;
    assign bus.EXTERN  = ctrl.ext;
    assign bus.Ain     = ctrl.ain;
    assign bus.Gin     = ctrl.gin;
    assign bus.Gout    = ctrl.gout;
    assign bus.FN      = ctrl.fn;
    assign bus.DONE    = ctrl.done;
    assign bus.ILLEGAL = ctrl.ill;
    assign bus.BUSY    = (state != T0);
    assign dbg_state   = state;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-step expected control vectors plus a per-cycle bus-ownership check.
module tb_alu_sequencer;
    logic       clk;
    logic       rstb;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    logic       mon_en;

`ifdef ILLEGAL_TRAP_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    alu_sequencer_if #(.N(10), .NREG(8)) bus ();

    alu_sequencer #(.N(10), .NREG(8)) dut (
        .CLKb      (clk),
        .RSTb      (rstb),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {IRin, Rin, Rout, EXTERN, Ain, Gin, Gout, FN, BUSY, DONE, ILLEGAL}
    function automatic logic [27:0] mk(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ext,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic [3:0] fn, input logic busy,
                                       input logic done, input logic ill);
        return {irin, rin, rout, ext, ain, gin, gout, fn, busy, done, ill};
    endfunction

    function automatic logic [27:0] observed();
        return {bus.IRin, bus.Rin, bus.Rout, bus.EXTERN, bus.Ain, bus.Gin, bus.Gout,
                bus.FN, bus.BUSY, bus.DONE, bus.ILLEGAL};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic exec, input logic [9:0] instr);
        bus.EXEC  = exec;
        bus.INSTR = instr;
        #1;
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [27:0] exp);
        logic [27:0] obs;
        obs = observed();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        total++;
        assert (dbg_state === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
        end
    endtask

    // Bus ownership and one-hot enables, every cycle after reset.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            assert (($countones(bus.Rout) + int'(bus.Gout) + int'(bus.EXTERN) <= 1) &&
                    ($countones(bus.Rin) <= 1)) else begin
                bad++;
                $error("FAIL bus_owner observed rout=%h gout=%b ext=%b rin=%h expected single_owner",
                       bus.Rout, bus.Gout, bus.EXTERN, bus.Rin);
            end
        end
    end

    logic [27:0] zero;

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        zero   = '0;
        rstb   = 1'b0;
        bus.EXEC  = 1'b0;
        bus.INSTR = '0;
        repeat (3) tick();
        rstb   = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("reset_outputs", zero);
        chk_state("reset_state", 2'd0);

        // LOAD R3
        drive(1'b1, 10'b0000_011_000);
        chk("load_t0_irin", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        tick(); drive(1'b0, '0);
        chk("load_t1", mk(0, 8'h08, 8'h00, 1, 0, 0, 0, 4'h0, 1, 1, 0));
        tick();
        chk("load_idle", zero);

        // ADD R1,R2
        drive(1'b1, 10'b0010_001_010);
        tick(); drive(1'b0, '0);
        chk("add_t1", mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'h0, 1, 0, 0));
        tick();
        chk("add_t2", mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 4'h2, 1, 0, 0));
        tick();
        chk("add_t3", mk(0, 8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1, 1, 0));
        tick();
        chk("add_idle", zero);

        // LSL R5,R6
        drive(1'b1, 10'b1001_101_110);
        tick(); drive(1'b0, '0);
        chk("lsl_t1", mk(0, 8'h00, 8'h40, 0, 0, 1, 0, 4'h9, 1, 0, 0));
        tick();
        chk("lsl_t2", mk(0, 8'h20, 8'h00, 0, 0, 0, 1, 4'h0, 1, 1, 0));
        tick();
        chk("lsl_idle", zero);

        // MOV R7,R0
        drive(1'b1, 10'b0001_111_000);
        tick(); drive(1'b0, '0);
        chk("mov_t1", mk(0, 8'h80, 8'h01, 0, 0, 0, 0, 4'h0, 1, 1, 0));
        tick();
        chk("mov_idle", zero);

        // SUB R4,R3 with a stray EXEC in T2
        drive(1'b1, 10'b0011_100_011);
        tick(); drive(1'b0, '0);
        chk("sub_t1", mk(0, 8'h00, 8'h10, 0, 1, 0, 0, 4'h0, 1, 0, 0));
        tick();
        chk("sub_t2", mk(0, 8'h00, 8'h08, 0, 0, 1, 0, 4'h3, 1, 0, 0));
        drive(1'b1, 10'b0000_000_000);
        chk("sub_t2_exec_ignored", mk(0, 8'h00, 8'h08, 0, 0, 1, 0, 4'h3, 1, 0, 0));
        tick(); drive(1'b0, '0);
        chk("sub_t3", mk(0, 8'h10, 8'h00, 0, 0, 0, 1, 4'h0, 1, 1, 0));
        tick();
        chk("sub_no_second", zero);
        tick();
        chk("sub_still_idle", zero);

        // ADD R2,R2: Rx == Ry
        drive(1'b1, 10'b0010_010_010);
        tick(); drive(1'b0, '0);
        chk("addrr_t1", mk(0, 8'h00, 8'h04, 0, 1, 0, 0, 4'h0, 1, 0, 0));
        tick();
        chk("addrr_t2", mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 4'h2, 1, 0, 0));
        tick();
        chk("addrr_t3", mk(0, 8'h04, 8'h00, 0, 0, 0, 1, 4'h0, 1, 1, 0));
        tick();
        chk("addrr_idle", zero);

        // EXEC held high: INV R2,R1 then MOV R1,R6 after one idle cycle
        drive(1'b1, 10'b0100_010_001);
        tick();
        chk("inv_t1", mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 4'h4, 1, 0, 0));
        tick();
        chk("inv_t2", mk(0, 8'h04, 8'h00, 0, 0, 0, 1, 4'h0, 1, 1, 0));
        drive(1'b1, 10'b0001_001_110);
        tick();
        chk("held_gap_irin", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        tick(); drive(1'b0, '0);
        chk("held_mov_t1", mk(0, 8'h02, 8'h40, 0, 0, 0, 0, 4'h0, 1, 1, 0));
        tick();
        chk("held_idle", zero);

        // XOR R6,R5 with reset in T2
        drive(1'b1, 10'b1000_110_101);
        tick(); drive(1'b0, '0);
        chk("xor_t1", mk(0, 8'h00, 8'h40, 0, 1, 0, 0, 4'h0, 1, 0, 0));
        tick();
        chk("xor_t2", mk(0, 8'h00, 8'h20, 0, 0, 1, 0, 4'h8, 1, 0, 0));
        rstb = 1'b0;
        tick();
        chk("xor_reset", zero);
        chk_state("xor_reset_state", 2'd0);
        rstb = 1'b1;
        tick();
        chk("xor_no_rin", zero);

        // Reserved 1110
        drive(1'b1, 10'b1110_011_010);
        tick(); drive(1'b0, '0);
        chk("rsv_t1", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1, 1, ILL));
        tick();
        chk("rsv_idle", zero);
        chk_state("rsv_state", 2'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
